// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - two-operand load sequencer with registered compare result
module operand_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] din,
    input  logic       load,
    input  logic       abort,
    input  logic       greatt,
    output logic       ready,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       result_valid,
    output logic       result_gt,
    output logic       result_eq,
    output logic       result_lt,
    output logic [7:0] cmp_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EVAL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] a_q, a_d;
    logic [5:0] b_q, b_d;
    logic       valid_q, valid_d;
    logic       gt_q, gt_d;
    logic       eq_q, eq_d;
    logic       lt_q, lt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ops_equal;

    // Equality comes from the local operands, so a greatt glitch on equal
    // operands can never yield anything other than eq.
    assign ops_equal = (a_q == b_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= 6'd0;
            b_q     <= 6'd0;
            valid_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    a_d     = din;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (load) begin
                    b_d     = din;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                gt_d    = greatt & ~ops_equal;
                eq_d    = ops_equal;
                lt_d    = ~greatt & ~ops_equal;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                state_d = DONE;
            end
            DONE: begin
                if (load) begin
                    a_d     = din;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any load or evaluation on the same edge; operands
        // and the completed-comparison count survive it.
        if (abort) begin
            state_d = IDLE;
            a_d     = a_q;
            b_d     = b_q;
            cnt_d   = cnt_q;
            valid_d = 1'b0;
            gt_d    = 1'b0;
            eq_d    = 1'b0;
            lt_d    = 1'b0;
        end
    end

    assign ready        = (state_q != EVAL);
    assign x            = {2'b00, a_q};
    assign y            = {2'b00, b_q};
    assign result_valid = valid_q;
    assign result_gt    = gt_q;
    assign result_eq    = eq_q;
    assign result_lt    = lt_q;
    assign cmp_count    = cnt_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer
module tb_operand_sequencer;

    logic       clk;
    logic       reset_n;
    logic [5:0] din;
    logic       load;
    logic       abort;
    logic       greatt;
    logic       glitch;
    logic       ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       result_valid;
    logic       result_gt;
    logic       result_eq;
    logic       result_lt;
    logic [7:0] cmp_count;

    int checks;
    int errors;

    operand_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .din          (din),
        .load         (load),
        .abort        (abort),
        .greatt       (greatt),
        .ready        (ready),
        .x            (x),
        .y            (y),
        .result_valid (result_valid),
        .result_gt    (result_gt),
        .result_eq    (result_eq),
        .result_lt    (result_lt),
        .cmp_count    (cmp_count)
    );

    // Downstream comparator model; glitch forces a spurious greater-than.
    assign greatt = glitch | (x > y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic v, input logic g,
                              input logic e, input logic l, input logic [7:0] cnt);
        chk({tag, "_valid"}, {31'd0, result_valid}, {31'd0, v});
        chk({tag, "_gt"},    {31'd0, result_gt},    {31'd0, g});
        chk({tag, "_eq"},    {31'd0, result_eq},    {31'd0, e});
        chk({tag, "_lt"},    {31'd0, result_lt},    {31'd0, l});
        chk({tag, "_cnt"},   {24'd0, cmp_count},    {24'd0, cnt});
    endtask

    task automatic do_pair(input logic [5:0] a, input logic [5:0] b);
        load = 1'b1; din = a; tick();
        din = b; tick();
        load = 1'b0; tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        din     = 6'd0;
        load    = 1'b0;
        abort   = 1'b0;
        glitch  = 1'b0;

        #3;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk_result("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // A=45, B=12
        load = 1'b1; din = 6'd45; tick();
        chk("a45_x", {24'd0, x}, 32'd45);
        chk("a45_ready", {31'd0, ready}, 32'd1);
        din = 6'd12; tick();
        chk("b12_y", {24'd0, y}, 32'd12);
        chk("eval_ready", {31'd0, ready}, 32'd0);
        chk("eval_valid", {31'd0, result_valid}, 32'd0);
        load = 1'b0; tick();
        chk_result("r45_12", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        chk("done_ready", {31'd0, ready}, 32'd1);

        // Equal operands with greatt forced high during EVAL
        load = 1'b1; din = 6'd7; tick();
        chk("done_load_valid", {31'd0, result_valid}, 32'd0);
        din = 6'd7; tick();
        glitch = 1'b1; load = 1'b0; tick();
        glitch = 1'b0;
        chk_result("r7_7", 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);

        do_pair(6'd0, 6'd63);
        chk_result("r0_63", 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
        do_pair(6'd63, 6'd0);
        chk_result("r63_0", 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        chk("r63_0_x", {24'd0, x}, 32'd63);

        // Abort from DONE returns to IDLE, clears results, keeps count
        abort = 1'b1; tick();
        abort = 1'b0;
        chk_result("abort_done", 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        chk("abort_done_x", {24'd0, x}, 32'd63);

        // Continuous load: 5, 9, 3
        load = 1'b1; din = 6'd5; tick();
        chk("hold_a_ready", {31'd0, ready}, 32'd1);
        din = 6'd9; tick();
        chk("hold_b_ready", {31'd0, ready}, 32'd0);
        din = 6'd3; tick();
        chk("hold_x", {24'd0, x}, 32'd5);
        chk("hold_y", {24'd0, y}, 32'd9);
        chk("hold_done_ready", {31'd0, ready}, 32'd1);
        chk_result("r5_9", 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
        tick();
        chk("hold_next_x", {24'd0, x}, 32'd3);
        chk("hold_next_valid", {31'd0, result_valid}, 32'd0);

        // In WAIT_B: abort together with load
        abort = 1'b1; din = 6'd20; tick();
        abort = 1'b0;
        chk("abort_wb_y", {24'd0, y}, 32'd9);
        chk("abort_wb_x", {24'd0, x}, 32'd3);
        chk_result("abort_wb", 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        din = 6'd11; tick();
        chk("post_abort_x", {24'd0, x}, 32'd11);
        chk("post_abort_y", {24'd0, y}, 32'd9);

        // Abort during EVAL
        din = 6'd2; tick();
        chk("pre_abort_eval_ready", {31'd0, ready}, 32'd0);
        load = 1'b0; abort = 1'b1; tick();
        abort = 1'b0;
        chk_result("abort_eval", 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        chk("abort_eval_ready", {31'd0, ready}, 32'd1);
        tick();
        chk("abort_eval_stay", {31'd0, result_valid}, 32'd0);

        // Wrap of the comparison count: 5 + 250 = 255, then one more
        for (int i = 0; i < 250; i++) begin
            do_pair(6'(i), 6'(i + 1));
        end
        chk("cnt_255", {24'd0, cmp_count}, 32'd255);
        do_pair(6'd40, 6'd40);
        chk_result("cnt_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);

        // Reset asserted between edges while in EVAL
        load = 1'b1; din = 6'd33; tick();
        din = 6'd17; tick();
        chk("pre_rst_ready", {31'd0, ready}, 32'd0);
        load = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_x", {24'd0, x}, 32'd0);
        chk("mid_rst_y", {24'd0, y}, 32'd0);
        chk_result("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #2 reset_n = 1'b1;
        tick();
        chk_result("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        load = 1'b1; din = 6'd21; tick();
        chk("post_rst_x", {24'd0, x}, 32'd21);
        chk("post_rst_y", {24'd0, y}, 32'd0);
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
